// File: rtl/arb_pkg.sv
// arb_pkg: types shared by the 3-way arbiter and the burst engine.
// Requester count, engine FSM states and grant decode helpers.
package arb_pkg;

  localparam int NUM_REQ = 3;
  localparam int SRC_W   = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    XFER,
    RELEASE
  } state_t;

  function automatic logic grant_ok(
    input logic [NUM_REQ-1:0] v
  );
    return $onehot(v);
  endfunction

  function automatic logic [SRC_W-1:0] grant_idx(
    input logic [NUM_REQ-1:0] v
  );
    logic [SRC_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (v[i]) r = SRC_W'(i);
    return r;
  endfunction

endpackage

// File: rtl/beat_counter.sv
// beat_counter: beats remaining in the current burst.
// Loads the burst length, counts down per accepted beat.
module beat_counter #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             decrement,
  output logic             is_last
);

  logic [LEN_W-1:0] beat_cnt;

  // load wins over decrement; never wraps below zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      beat_cnt <= '0;
    else if (load)
      beat_cnt <= load_val;
    else if (decrement && beat_cnt != '0)
      beat_cnt <= beat_cnt - LEN_W'(1);
  end

  assign is_last = (beat_cnt == LEN_W'(1));

endmodule

// File: rtl/burst_xfer_engine.sv
// burst_xfer_engine: moves a granted requester's burst to the sink.
// Registered beat output, per-beat pull from the source, abort on lost grant.
module burst_xfer_engine
  import arb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             g,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0][LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]             rd_en,
  output logic                           out_valid,
  output logic [DATA_W-1:0]              out_data,
  output logic [SRC_W-1:0]               out_src,
  output logic                           out_last,
  input  logic                           out_ready,
  output logic [NUM_REQ-1:0]             done,
  output logic                           err
);

  state_t              state, state_nx;
  logic [SRC_W-1:0]    src, src_nx;
  logic [NUM_REQ-1:0]  src_hot;
  logic                g_src;
  logic                hs;
  logic [DATA_W-1:0]   data_nx;
  logic                valid_nx;
  logic [NUM_REQ-1:0]  done_nx;
  logic                err_nx;
  logic                cnt_load;
  logic                cnt_dec;
  logic [LEN_W-1:0]    cnt_val;
  logic                is_last;

  assign src_hot = NUM_REQ'(1) << src;
  assign g_src   = |(g & src_hot);
  assign hs      = out_valid & out_ready;
  assign cnt_val = (req_len[src] == '0) ? LEN_W'(1)
                                        : req_len[src];

  beat_counter #(
    .LEN_W(LEN_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .decrement(cnt_dec),
    .is_last  (is_last)
  );

  // next state, next beat register values and per-cycle pulses
  always_comb begin
    state_nx = state;
    src_nx   = src;
    data_nx  = out_data;
    valid_nx = out_valid;
    done_nx  = '0;
    err_nx   = 1'b0;
    rd_en    = '0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_ok(g)) begin
          state_nx = LOAD;
          src_nx   = grant_idx(g);
        end else if (g != '0) begin
          err_nx = 1'b1;
        end
      end
      LOAD: begin
        if (!g_src) begin
          err_nx   = 1'b1;
          valid_nx = 1'b0;
          state_nx = IDLE;
        end else begin
          cnt_load = 1'b1;
          data_nx  = req_data[src];
          valid_nx = 1'b1;
          rd_en    = src_hot;
          state_nx = XFER;
        end
      end
      XFER: begin
        if (!g_src) begin
          err_nx   = 1'b1;
          valid_nx = 1'b0;
          state_nx = IDLE;
        end else if (hs) begin
          cnt_dec = 1'b1;
          if (is_last) begin
            valid_nx = 1'b0;
            done_nx  = src_hot;
            state_nx = RELEASE;
          end else begin
            data_nx = req_data[src];
            rd_en   = src_hot;
          end
        end
      end
      RELEASE: begin
        if (g == '0)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // state, source and registered sink-side outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      src       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      src       <= src_nx;
      out_valid <= valid_nx;
      out_data  <= data_nx;
      done      <= done_nx;
      err       <= err_nx;
    end
  end

  assign out_src  = src;
  assign out_last = out_valid & is_last;

endmodule

// File: tb/tb_burst_xfer_engine.sv
// tb_burst_xfer_engine: randomized bench with a beat-list reference model.
// Requesters are modelled as beat streams advanced by rd_en.
module tb_burst_xfer_engine;

  logic            clk;
  logic            reset;
  logic [2:0]      g;
  logic [2:0][7:0] req_data;
  logic [2:0][3:0] req_len;
  logic [2:0]      rd_en;
  logic            out_valid;
  logic [7:0]      out_data;
  logic [1:0]      out_src;
  logic            out_last;
  logic            out_ready;
  logic [2:0]      done;
  logic            err;

  int errors;
  int checks;
  int ptr [3];

  burst_xfer_engine #(
    .DATA_W(8),
    .LEN_W (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .g        (g),
    .req_data (req_data),
    .req_len  (req_len),
    .rd_en    (rd_en),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_src  (out_src),
    .out_last (out_last),
    .out_ready(out_ready),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] beat_val(input int i, input int n);
    return 8'((i * 80 + n * 13 + 5) % 256);
  endfunction

  task automatic cycle_begin();
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      req_data[i] = beat_val(i, ptr[i]);
  endtask

  task automatic cycle_end();
    for (int i = 0; i < 3; i++)
      if (rd_en[i]) ptr[i]++;
  endtask

  task automatic run_burst(input int i, input int len,
                           input int stall_first,
                           input int stall_pct,
                           input int hold);
    int L, base, k, n, bubble, first_v;
    bit fin, prev_final, stalled;
    logic [7:0] held;
    logic [2:0] oh;
    oh = 3'b001 << i;
    L = (len == 0) ? 1 : len;
    base = ptr[i];
    k = 0; n = 0; bubble = 0; first_v = -1;
    fin = 0; prev_final = 0; stalled = 0; held = '0;
    req_len[i] = 4'(len);
    while (!fin && n < 200) begin
      cycle_begin();
      g = (prev_final && hold == 0) ? 3'b000 : oh;
      if (k == 0 && stall_first > 0 && out_valid) begin
        out_ready = 1'b0;
        stall_first--;
      end else begin
        out_ready = ($urandom_range(99) < stall_pct) ? 1'b0 : 1'b1;
      end
      #1;
      if (stalled) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, held);
      end
      chk("rd_en_src", rd_en & ~oh, 0);
      chk("err_quiet", err, 0);
      if (out_valid && first_v < 0) first_v = n;
      if (out_valid && !out_ready) chk("rd_en_stall", rd_en, 0);
      if (!out_valid && k > 0 && k < L) bubble++;
      if (done != 0 || prev_final) begin
        chk("done", done, prev_final ? oh : 3'b000);
        chk("done_beats", k, L);
        fin = 1;
      end
      prev_final = 0;
      if (out_valid && out_ready) begin
        chk("beat_in_range", k < L, 1);
        chk("data", out_data, beat_val(i, base + k));
        chk("src", out_src, i);
        chk("last", out_last, k == L - 1);
        if (k == L - 1) prev_final = 1;
        k++;
      end else if (out_valid) begin
        chk("last_stall", out_last, k == L - 1);
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      cycle_end();
      n++;
    end
    chk("burst_timeout", fin, 1);
    chk("first_beat_lat", first_v, 2);
    chk("no_bubble", bubble, 0);
    for (int h = 0; h < hold; h++) begin
      cycle_begin();
      g = oh;
      out_ready = 1'($urandom_range(1));
      #1;
      chk("rel_valid", out_valid, 0);
      chk("rel_rd_en", rd_en, 0);
      chk("rel_done", done, 0);
      cycle_end();
    end
    if (hold > 0) begin
      cycle_begin();
      g = 3'b000;
      #1;
      chk("rel_exit_err", err, 0);
      cycle_end();
    end
  endtask

  task automatic abort_test();
    int k, n, base;
    k = 0; n = 0;
    base = ptr[0];
    req_len[0] = 4'd4;
    while (k < 2 && n < 20) begin
      cycle_begin();
      g = 3'b001;
      out_ready = 1'b1;
      #1;
      if (out_valid && out_ready) begin
        chk("ab_data", out_data, beat_val(0, base + k));
        k++;
      end
      cycle_end();
      n++;
    end
    chk("ab_reach", k, 2);
    cycle_begin();
    g = 3'b000;
    out_ready = 1'b0;
    #1;
    chk("ab_valid_hold", out_valid, 1);
    chk("ab_err_early", err, 0);
    chk("ab_rd_en", rd_en, 0);
    cycle_end();
    cycle_begin();
    #1;
    chk("ab_err", err, 1);
    chk("ab_valid_fall", out_valid, 0);
    chk("ab_done", done, 0);
    cycle_end();
    for (int j = 0; j < 3; j++) begin
      cycle_begin();
      out_ready = 1'b1;
      #1;
      chk("ab_err_once", err, 0);
      chk("ab_done_quiet", done, 0);
      chk("ab_valid_low", out_valid, 0);
      cycle_end();
    end
  endtask

  task automatic bad_grant_test();
    cycle_begin();
    g = 3'b011;
    #1;
    chk("bad_err_early", err, 0);
    cycle_end();
    cycle_begin();
    g = 3'b000;
    #1;
    chk("bad_err", err, 1);
    chk("bad_no_load", rd_en, 0);
    cycle_end();
    cycle_begin();
    #1;
    chk("bad_err_once", err, 0);
    chk("bad_valid", out_valid, 0);
    chk("bad_rd_en", rd_en, 0);
    cycle_end();
  endtask

  task automatic reset_test();
    int n;
    n = 0;
    req_len[1] = 4'd5;
    while (!out_valid && n < 20) begin
      cycle_begin();
      g = 3'b010;
      out_ready = 1'b0;
      #1;
      cycle_end();
      n++;
    end
    chk("rst_pre_valid", out_valid, 1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async",
        {out_valid, out_data, out_src, out_last, rd_en, done, err}, 0);
    for (int j = 0; j < 2; j++) begin
      cycle_begin();
      g = 3'b000;
      #1;
      chk("rst_hold_done", done, 0);
      chk("rst_hold_err", err, 0);
      cycle_end();
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_after",
        {out_valid, out_data, out_src, out_last, rd_en, done, err}, 0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 3; i++) ptr[i] = 0;
    reset = 1'b1;
    g = 3'b000;
    out_ready = 1'b0;
    req_len = '0;
    for (int i = 0; i < 3; i++) req_data[i] = beat_val(i, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("reset_state",
        {out_valid, out_data, out_src, out_last, rd_en, done, err}, 0);
    @(negedge clk);
    reset = 1'b0;

    run_burst(0, 3, 0, 0, 2);
    run_burst(1, 2, 4, 0, 0);
    run_burst(2, 0, 0, 0, 1);
    abort_test();
    run_burst(1, 3, 0, 0, 0);
    bad_grant_test();
    run_burst(0, 2, 1, 0, 1);
    reset_test();
    run_burst(2, 4, 0, 20, 0);

    for (int t = 0; t < 25; t++)
      run_burst(int'($urandom_range(2)), int'($urandom_range(6)),
                int'($urandom_range(2)), 30, int'($urandom_range(3)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
